// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multicycle RV32I datapath with one shared ALU and one
//   shared instruction/data memory. It runs one instruction at a time and,
//   in every cycle, drives the datapath mux selects and write enables.
//
//   Parameters
//     MEM_HANDSHAKE : 1 = honour MemReady, 0 = memory is treated as always ready
//     EXT_BRANCH    : 1 = blt/bge/bltu/bgeu supported, 0 = only beq/bne
//
//   Ports
//     clk, reset      : clock (rising edge), synchronous active-high reset
//     op, funct3,
//     funct7b5        : fields of the current instruction
//     Zero, Neg, Ovf,
//     Carry           : ALU flags from the branch compare (a - b)
//     MemReady        : memory completes the current access this cycle
//     PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//     RegWrite, ImmSrc, ALUControl : datapath controls
//     Illegal         : sticky trap flag (set while in TRAP)
//     State           : current state, for debug
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit EXT_BRANCH    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       Neg,
  input  logic       Ovf,
  input  logic       Carry,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    LINK     = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  state_t state_q, state_d;
  logic   mem_ready;

  assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  function automatic logic [2:0] imm_decode(input logic [6:0] opc);
    case (opc)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_decode = 3'b000;
      OP_STORE:                   imm_decode = 3'b001;
      OP_BRANCH:                  imm_decode = 3'b010;
      OP_JAL:                     imm_decode = 3'b011;
      OP_LUI, OP_AUIPC:           imm_decode = 3'b100;
      default:                    imm_decode = 3'b000;
    endcase
  endfunction

  // Subtract only for R-type (op[5]=1) with bit 30 set; addi ignores bit 30.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic       op5,
                                            input logic       f7b5);
    case (f3)
      3'b000:  alu_decode = (op5 & f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

  function automatic logic branch_legal(input logic [2:0] f3);
    if (f3 == 3'b010 || f3 == 3'b011) branch_legal = 1'b0;
    else if (!EXT_BRANCH && f3[2])    branch_legal = 1'b0;
    else                              branch_legal = 1'b1;
  endfunction

  // Flags come from a - b: signed less-than is Neg^Ovf, unsigned
  // greater-or-equal is the carry out of a + ~b + 1.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic z, input logic n,
                                        input logic v, input logic c);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = ~z;
      3'b100:  branch_taken = n ^ v;
      3'b101:  branch_taken = ~(n ^ v);
      3'b110:  branch_taken = ~c;
      3'b111:  branch_taken = c;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = branch_legal(funct3) ? BRANCH : TRAP;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JAL:      state_d = ALUWB;
      JALR:     state_d = LINK;
      LINK:     state_d = FETCH;
      LUI:      state_d = ALUWB;
      AUIPC:    state_d = ALUWB;
      TRAP:     state_d = TRAP;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Output decode; reset gates every output combinationally so a reset
  // raised mid-instruction suppresses writes in that same cycle.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    ImmSrc     = 3'b000;
    ALUControl = ALU_ADD;
    Illegal    = 1'b0;
    State      = FETCH;
    if (!reset) begin
      State  = state_q;
      ImmSrc = imm_decode(op);
      case (state_q)
        FETCH: begin
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        MEMREAD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        EXECR: begin
          ALUSrcA    = 2'b10;
          ALUControl = alu_decode(funct3, op[5], funct7b5);
        end
        EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ALUControl = alu_decode(funct3, op[5], funct7b5);
        end
        ALUWB:    RegWrite = 1'b1;
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUControl = ALU_SUB;
          PCWrite    = branch_taken(funct3, Zero, Neg, Ovf, Carry);
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
        end
        JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        LINK: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          RegWrite  = 1'b1;
        end
        LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
        end
        AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        TRAP:     Illegal = 1'b1;
        default:  Illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multicycle RV32I control FSM. It sequences the shared-ALU, shared-memory datapath one instruction at a time, driving the mux selects and write enables each cycle. It generalises the single-cycle controller to lw/sw, R/I-ALU, all six branches, jal, jalr, lui and auipc. It adds a memory-ready stall handshake and an illegal-opcode trap.

Parameters:
MEM_HANDSHAKE, 1, 1 = honour MemReady; 0 = MemReady is internally tied to 1.
EXT_BRANCH, 1, 1 = blt/bge/bltu/bgeu supported; 0 = only beq/bne supported, other branch funct3 values trap.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  instruction opcode, bits [6:0]
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
Zero  in  1  ALU result == 0
Neg  in  1  ALU result MSB
Ovf  in  1  signed overflow of the ALU subtraction
Carry  in  1  carry-out of a + ~b + 1 (1 means a >= b unsigned)
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  PC load enable
AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction and OldPC register load enable
ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
RegWrite  out  1  register file write enable
ImmSrc  out  3  immediate type: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
ALUControl  out  4  ALU operation: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu
Illegal  out  1  sticky trap flag
State  out  4  current state, for debug

Behaviour:
- State register is a single Moore FSM. On reset it goes to FETCH; Illegal clears to 0.
- While reset is high, all enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0. All other outputs are 0 during reset except State, which reads FETCH.
- Any output not listed for a state is 0. ImmSrc is decoded from op in every state: I-type for lw, I-ALU and jalr; S for sw; B for branches; J for jal; U for lui and auipc.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are each asserted only when MemReady=1.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut captures the branch/jal target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH (funct3 010 or 011 -> TRAP; when EXT_BRANCH=0, also 100..111 -> TRAP)
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - any other op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMWRITE if op[5]=1, otherwise MEMREAD.
- MEMREAD: AdrSrc=1. Holds while MemReady=0; goes to MEMWB when MemReady=1.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held high through stall cycles. Goes to FETCH in the cycle MemReady=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from funct decode, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUControl from funct decode, then ALUWB.
- Funct decode by funct3:
  - 000: sub when op[5] & funct7b5, else add
  - 001: sll; 010: slt; 011: sltu; 100: xor
  - 101: sra when funct7b5, else srl
  - 110: or; 111: and
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite = taken, then FETCH. Taken by funct3:
  - 000 (beq): Zero; 001 (bne): !Zero
  - 100 (blt): Neg^Ovf; 101 (bge): !(Neg^Ovf)
  - 110 (bltu): !Carry; 111 (bgeu): Carry
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (which writes OldPC+4 to rd).
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1, then LINK.
- LINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, then FETCH. rs1 is consumed in JALR, before LINK writes, so rd == rs1 is safe.
- LUI: ALUSrcA=11, ALUSrcB=01, add, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, add, then ALUWB.
- TRAP: all enables 0, Illegal=1. Absorbing state; only reset exits it.
- Reset asserted mid-instruction: next edge goes to FETCH with no write enables asserted in between.
- Instruction latency with no stalls: branch 3 cycles; R/I-ALU, lui, auipc, sw, jal, jalr 4; lw 5. Each stall cycle adds 1.

Test Plan:
- lw (op 0000011), MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; RegWrite=1 with ResultSrc=01 only in cycle 5.
- sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite high for 4 consecutive cycles, AdrSrc=1 throughout, back in FETCH on cycle 8.
- add then sub (R-type, funct3=000, funct7b5=0 then 1) -> ALUControl in EXECR is 0000, then 0001; I-type addi with funct7b5=1 -> 0000.
- blt with Neg=1, Ovf=0 -> PCWrite=1 in BRANCH; bgeu with Carry=0 -> PCWrite=0; EXT_BRANCH=0 with blt -> TRAP, Illegal=1.
- jalr -> JALR asserts PCWrite with ResultSrc=10; LINK asserts RegWrite with ALUSrcA=01, ALUSrcB=10.
- op=1111111 -> TRAP with Illegal stuck at 1 for 10 cycles; reset pulse -> FETCH, Illegal=0, no enables asserted while reset is high.
